pipe_skid_stage: RTL and testbench

- Generic, parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Generalises the fixed if_id/id_ex/ex_mem/mem_wb stage registers: any packed stage struct is passed through as a WIDTH-bit vector.
- Adds back-pressure, stall and flush, with fully registered in_ready so ready never combinationally spans stages.
- Instantiated once per pipeline boundary, between producer stage N and consumer stage N+1.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_sat_counter.sv | 31 +++
 rtl/pipe_skid_stage.sv | 131 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the generic pipeline stage
//               register with skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Number of entries held: 0 (empty), 1 (main), 2 (main + skid)
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  localparam int OCC_W = 2;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sat_counter
// Description : Saturating up-counter with asynchronous active-high reset.
//               Sticks at all-ones once reached; cleared only by rst.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_cnt;

  // Count up on inc, holding at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign q = r_cnt;

endmodule : pipe_sat_counter
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : Parametrised pipeline stage register with valid/ready
//               handshake and a 2-entry skid buffer. in_ready is decoded
//               from the state register only, so ready never forms a
//               combinational path across stages. Output data always comes
//               from the main register; the skid register catches the one
//               beat accepted while the consumer is stalling.
//               Optional performance counters are enabled by defining the
//               macro PIPE_SKID_PERF_CNT_EN; otherwise stall_cnt and
//               bubble_cnt are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  pipe_state_e      r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic             w_in_fire;
  logic             w_out_fire;

  assign out_valid  = (r_state != PS_EMPTY);
  assign in_ready   = (r_state != PS_FULL);
  assign out_data   = r_main;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Decode entry count from the state register
  always_comb begin
    occupancy = '0;
    case (r_state)
      PS_EMPTY: occupancy = OCC_W'(0);
      PS_ONE:   occupancy = OCC_W'(1);
      PS_FULL:  occupancy = OCC_W'(2);
      default:  occupancy = '0;
    endcase
  end

  // Stage FSM and data registers; flush squashes everything including
  // a same-cycle input beat, and data registers load only on real moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PS_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= PS_EMPTY;
    end else begin
      case (r_state)
        PS_EMPTY: begin
          if (w_in_fire) begin
            r_main  <= in_data;
            r_state <= PS_ONE;
          end
        end
        PS_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data;
          end else if (w_in_fire) begin
            r_skid  <= in_data;
            r_state <= PS_FULL;
          end else if (w_out_fire) begin
            r_state <= PS_EMPTY;
          end
        end
        PS_FULL: begin
          // in_ready is low here, so only the drain path exists
          if (w_out_fire) begin
            r_main  <= r_skid;
            r_state <= PS_ONE;
          end
        end
        default: begin
          r_state <= PS_EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_PERF_CNT_EN
  logic w_stall_inc;
  logic w_bubble_inc;

  assign w_stall_inc  = out_valid & ~out_ready & ~flush;
  assign w_bubble_inc = ~out_valid;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall_inc),
    .q   (stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_bubble_inc),
    .q   (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule : pipe_skid_stage
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_stage
// Description : Self-checking bench for pipe_skid_stage. A queue-based
//               reference model holds the accepted-but-undelivered beats;
//               valid/ready/occupancy/data are all derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

  localparam int WIDTH = 64;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  int checks;
  int errors;

  logic [WIDTH-1:0] m_q[$];
  int               m_stall;
  int               m_bubble;

  pipe_skid_stage #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every DUT output against the model (called away from edges)
  task automatic check_outputs();
    chk("out_valid", {63'd0, out_valid}, {63'd0, (m_q.size() != 0)});
    chk("in_ready",  {63'd0, in_ready},  {63'd0, (m_q.size() < 2)});
    chk("occupancy", {62'd0, occupancy}, 64'(m_q.size()));
    if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
`ifdef PIPE_SKID_PERF_CNT_EN
    chk("stall_cnt",  64'(stall_cnt),  64'(m_stall));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`else
    chk("stall_cnt",  64'(stall_cnt),  64'd0);
    chk("bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
  endtask

  // One cycle: drive, check at negedge, probe ready path, advance model
  task automatic step(input logic iv, input logic [WIDTH-1:0] id,
                      input logic ordy, input logic fl);
    bit ofire, ifire, stall_c, bub_c;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    check_outputs();
    out_ready = ~ordy;
    #1;
    chk("in_ready_no_comb", {63'd0, in_ready}, {63'd0, (m_q.size() < 2)});
    out_ready = ordy;
    #1;
    ofire   = (m_q.size() != 0) && ordy;
    ifire   = iv && (m_q.size() < 2);
    stall_c = (m_q.size() != 0) && !ordy && !fl;
    bub_c   = (m_q.size() == 0);
    @(posedge clk);
    if (stall_c && m_stall < SAT) m_stall++;
    if (bub_c && m_bubble < SAT) m_bubble++;
    if (fl) begin
      m_q.delete();
    end else begin
      if (ofire) void'(m_q.pop_front());
      if (ifire) m_q.push_back(id);
    end
    #1;
  endtask

  task automatic async_reset_check();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
    chk("rst_out_data",  out_data,           64'd0);
    chk("rst_stall",     64'(stall_cnt),     64'd0);
    chk("rst_bubble",    64'(bubble_cnt),    64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_stall  = 0;
    m_bubble = 0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    m_stall   = 0;
    m_bubble  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    void'($urandom(32'd20240611));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_data", out_data, 64'd0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Streaming at full rate: each beat visible one cycle later, occupancy 1
    for (int i = 1; i <= 16; i++) step(1'b1, 64'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure: fill with 0xA, 0xB then drain
    step(1'b1, 64'hA, 1'b0, 1'b0);
    step(1'b1, 64'hB, 1'b0, 1'b0);
    step(1'b1, 64'hD, 1'b0, 1'b0);
    chk("bp_occupancy", {62'd0, occupancy}, 64'd2);
    chk("bp_hold_A",    out_data,           64'hA);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush while full with a simultaneous 0xC offer (in_ready low)
    step(1'b1, 64'h1A, 1'b0, 1'b0);
    step(1'b1, 64'h1B, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b0, 1'b1);
    chk("flush_occupancy", {62'd0, occupancy}, 64'd0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    // Flush in ONE with an accepted 0xC: the beat is squashed
    step(1'b1, 64'h2A, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);

    // Long stall: stall counter saturates
    step(1'b1, 64'h55, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);

    // Async reset while full
    step(1'b1, 64'h77, 1'b0, 1'b0);
    chk("pre_rst_occupancy", {62'd0, occupancy}, 64'd2);
    async_reset_check();
    step(1'b0, '0, 1'b0, 1'b0);

    // Randomised traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      logic [WIDTH-1:0] d;
      d = {$urandom, $urandom};
      step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 63) == 0));
    end

    // Drain and final state
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("final_occupancy", {62'd0, occupancy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_skid_stage
`default_nettype wire
